// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start-bit qualification, mid-cell sampling, LSB first, rxrdy/read handshake.
// Define UART_RX_PARITY_EN to receive an even parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 read,
  output logic [DATA_BITS-1:0] data,
  output logic                 rxrdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] HALF_CELL = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t               state, state_nx;
  logic                 sync1, rx_s;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [IW-1:0]        idx, idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 load;

  // NOTE: synchronizer resets to the idle line level so reset release cannot look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep both flops sampling the same edge; blocking would collapse them into one.
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_nx;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_nx;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    shreg_nx = shreg;
    load     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nx = par_bit;
`endif
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = START;
      end
      START: begin
        if (cnt == HALF_CELL) begin
          cnt_nx = '0;
          idx_nx = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        // cnt is cleared explicitly so OVERSAMPLE need not be a power of two.
        if (cnt == LAST_TICK) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
          idx_nx   = idx + 1'b1;
          if (idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST_TICK) begin
          cnt_nx     = '0;
          par_bit_nx = rx_s;
          state_nx   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == LAST_TICK) begin
          cnt_nx   = '0;
          load     = 1'b1;
          state_nx = rx_s ? IDLE : BRK;
        end
      end
      BRK: begin
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A load on the same clock as read wins: the byte stays unread and is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      rxrdy     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      data      <= shreg;
      frame_err <= ~rx_s;
      rxrdy     <= 1'b1;
      overrun   <= rxrdy & ~read;
    end else if (read) begin
      rxrdy   <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     parity_err <= 1'b0;
    else if (load) parity_err <= ^{shreg, par_bit};
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, hand-written corner sequences, random frames vs a byte-level model.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // rx is driven just after edge t0, so the load edge is t0 + 2 sync + 1 detect + half cell + remaining cells.
  localparam int LAT = 3 + OS / 2 + (DB + 1 + PB) * OS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          read = 1'b0;
  logic [DB-1:0] data;
  logic          rxrdy, frame_err, parity_err, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .read(read), .data(data),
    .rxrdy(rxrdy), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic rdy, input logic fe,
                           input logic pe, input logic ovr);
    check({tag, " data"}, 32'(data), 32'(d));
    check({tag, " rxrdy"}, 32'(rxrdy), 32'(rdy));
    check({tag, " frame_err"}, 32'(frame_err), 32'(fe));
    check({tag, " parity_err"}, 32'(parity_err), 32'(pe));
    check({tag, " overrun"}, 32'(overrun), 32'(ovr));
  endtask

  // Drives one frame starting at the current negedge; returns at the end of the stop cell with rx = stop.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (OS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (OS) @(negedge clk);
`endif
    rx = stop;
    repeat (OS) @(negedge clk);
  endtask

  task automatic pulse_read();
    rx = 1'b1;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    read = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       read_after;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[4];

  // Byte-level reference state.
  logic [7:0] m_data;
  logic       m_rdy, m_fe, m_pe, m_ovr;

  initial begin
    logic [7:0] b;
    logic       stop, pf, rd;
    int         gap;

    // bad stop, then valid frame; two back-to-back frames with no read in between
    tbl[0] = '{8'h3C, 1'b0, 1'b1, 4, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h81, 1'b1, 1'b1, 0, 8'h81, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h22, 1'b1, 1'b1, 2, 8'h22, 1'b1, 1'b0, 1'b1};

    do_reset();
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame latency: rxrdy must still be low one clock before the load edge.
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(negedge clk);
        check("latency rxrdy early", 32'(rxrdy), 32'd0);
        @(negedge clk);
        check("latency rxrdy on time", 32'(rxrdy), 32'd1);
      end
    join
    rx = 1'b1;
    check_all("0xA5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();
    check("read clears rxrdy", 32'(rxrdy), 32'd0);

    // Start-bit glitch shorter than half a cell is dropped.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_all("glitch", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, 1'b0);
      rx = 1'b1;
      check_all($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_rdy, tbl[i].exp_fe, 1'b0, tbl[i].exp_ovr);
      if (tbl[i].read_after) begin
        pulse_read();
        check($sformatf("tbl%0d read rxrdy", i), 32'(rxrdy), 32'd0);
        check($sformatf("tbl%0d read overrun", i), 32'(overrun), 32'd0);
      end
      repeat (tbl[i].gap) @(negedge clk);
    end

    // Read on the very clock of a load while a byte is still unread.
    send_frame(8'h33, 1'b1, 1'b0);
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(negedge clk);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
      end
    join
    rx = 1'b1;
    check_all("load+read", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    // Reset in the middle of the data bits of 0xFF aborts that frame.
    rx = 1'b0;
    repeat (OS) @(negedge clk);
    rx = 1'b1;
    repeat (3 * OS) @(negedge clk);
    do_reset();
    check_all("mid-frame reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    rx = 1'b1;
    check_all("0x0F after reset", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();
`ifdef UART_RX_PARITY_EN
    send_frame(8'h0F, 1'b1, 1'b1);
    rx = 1'b1;
    check_all("bad parity", 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_read();
`endif

    // Random frames against the byte-level model.
    do_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ovr = 1'b0;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      pf   = (PB != 0) && ($urandom_range(0, 3) == 0);
      rd   = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 3);
      if (!stop) gap += 4;
      send_frame(b, stop, pf);
      m_ovr  = m_rdy;
      m_data = b;
      m_fe   = ~stop;
      m_pe   = pf;
      m_rdy  = 1'b1;
      check_all($sformatf("rnd%0d", n), m_data, m_rdy, m_fe, m_pe, m_ovr);
      if (rd) begin
        pulse_read();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
        check($sformatf("rnd%0d read rxrdy", n), 32'(rxrdy), 32'(m_rdy));
        check($sformatf("rnd%0d read overrun", n), 32'(overrun), 32'(m_ovr));
      end
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
